adder_result_fnd: RTL and testbench
===================================

# adder_result_fnd

- Downstream consumer of the 2-bit adder stage.
- Latches operands `A`, `B` and the 3-bit result `{Co,S}` on a debounced button press.
- Shows them on the board's 4-digit common-anode 7-segment display (FND), using time-multiplexed scanning.
- Sits between the adder's combinational outputs and the board pins `seg`/`an`/`dp`/`led`.

## Interface
Parameters:
- `SCAN_DIV`, 100000: clock cycles per digit slot (1 kHz/digit at 100 MHz).
- `DEBOUNCE_CYC`, 1000000: consecutive stable cycles required to accept a button level change (10 ms).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `btn_load` in 1: raw asynchronous push button, active-high.
- `opa` in 2: adder operand A.
- `opb` in 2: adder operand B.
- `sum_in` in 3: adder result `{Co,S}`, range 0..6.
- `seg` out 7: segment cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp` out 1: decimal point, active-low; always 1.
- `an` out 4: digit anodes, active-low, one-hot-low.
- `valid` out 1: high once at least one capture has occurred since reset.

## Operation
- **Input path:** `btn_load` passes through a 2-FF synchronizer, then the debouncer (see Configuration), then a rising-edge detector. The edge detector produces a 1-cycle `load_pulse`.
- **Capture:** on `load_pulse`, the block registers `opa`, `opb`, `sum_in` into `a_q`, `b_q`, `r_q` and sets `valid`=1. Only press edges capture; holding or releasing the button captures nothing.
- **Scan counter:** `scan_cnt` runs 0..`SCAN_DIV`-1.
  - At terminal count it wraps to 0 and the 2-bit digit index advances 0→1→2→3→0.
- **Digit mapping:**
  - idx0 → `an`=1110, shows `r_q` in decimal.
  - idx1 → `an`=1101, blank.
  - idx2 → `an`=1011, shows `b_q`.
  - idx3 → `an`=0111, shows `a_q`.
- **Display while `valid`=0:** idx0, idx2 and idx3 show dash; idx1 stays blank.
- **Segment codes (`{g..a}`):**
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010
  - blank=1111111, dash=0111111
- **Out-of-range result:** `sum_in`=7 is impossible from the adder; if captured it displays as dash.
- **Registered outputs:** `seg`, `an`, `dp`, `valid` all come from flops, so no combinational glitches reach the pins.
- **Reset (including mid-debounce or mid-scan):**
  - Clears the synchronizer, debounce counter/level, edge-detect flop, `scan_cnt`, digit index, captures and `valid`.
  - Outputs after reset: `an`=1110, `seg`=0111111, `dp`=1, `valid`=0.
- **Button held through reset deassertion:** the debounced level starts at 0, so one capture occurs after `DEBOUNCE_CYC` stable cycles.

## Timing
- **Capture latency:** raw `btn_load` first sampled high at edge k and held stable:
  - `a_q`/`b_q`/`r_q`/`valid` update at edge k+`DEBOUNCE_CYC`+3.
  - `seg` reflects the new values at the next edge on which the relevant digit is active.
- **Digit slot width:** `an` changes exactly every `SCAN_DIV` cycles. `seg` changes on the same edge as `an`.
- **Bounce rejection:** any raw toggle during debounce restarts the stability count. A pulse shorter than `DEBOUNCE_CYC` cycles produces no capture.
- **Operand sampling:** operands are sampled on the capture edge itself. Changes to `opa`/`opb`/`sum_in` at other times are ignored.
- **Capture during scan:** a capture coincident with a digit switch displays the new value in the new slot; no mixed frame within a slot.

## Configuration
- Macro: `ADDER_FND_DEBOUNCE_EN`.
- **Defined:** the debouncer is present as described. The debounced level follows the synchronized input only after `DEBOUNCE_CYC` consecutive equal samples.
- **Undefined:** the debouncer is removed and the edge detector takes the synchronizer output directly. Capture latency becomes k+3. `DEBOUNCE_CYC` is ignored. Intended for fast simulation and for pre-debounced inputs.

## Test plan
All scenarios use `SCAN_DIV`=4, `DEBOUNCE_CYC`=8, macro defined unless noted.

1. **Reset state:** assert `reset` 3 cycles → `an`=1110, `seg`=0111111, `dp`=1, `valid`=0. Then `an` steps 1101, 1011, 0111, 1110 every 4 cycles; `seg` is blank in the 1101 slot and dash elsewhere.
2. **Basic capture:** `opa`=3, `opb`=2, `sum_in`=5; `btn_load` high 20 cycles → one capture at k+11, `valid`=1. Display slots: idx0 seg=0010010, idx2 seg=0100100, idx3 seg=0110000.
3. **Bounce rejection:** `btn_load` toggled every 3 cycles for 30 cycles, then held high → exactly one capture, at 11 cycles after the final rising edge.
4. **Hold and release:** capture `opa`=1, `opb`=0, `sum_in`=1; then change inputs to `opa`=2, `opb`=2, `sum_in`=4 while the button is held, then release → display still shows 1, 0, 1.
5. **Reset mid-operation:** reset asserted 5 cycles into debounce and mid-scan → no capture, outputs return to reset values, scan restarts at idx0.
6. **Macro undefined:** with `ADDER_FND_DEBOUNCE_EN` undefined, `btn_load` high 1 cycle, `opa`=2, `opb`=1, `sum_in`=3 → capture at k+3, idx0 seg=0110000.

Source files
------------

// File: rtl/adder_result_fnd.sv
// adder_result_fnd: captures adder operands/result on a debounced button press and scans them onto a 4-digit common-anode FND.
// Optional debouncer enabled by defining ADDER_FND_DEBOUNCE_EN; otherwise the synchronized button feeds the edge detector directly.
module adder_result_fnd #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_load,
  input  logic [1:0] opa,
  input  logic [1:0] opb,
  input  logic [2:0] sum_in,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       valid
);
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
  // Result 7 cannot come from a 2-bit adder, so it maps to dash.
  localparam logic [6:0] SEG_LUT [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                         7'b0011001, 7'b0010010, 7'b0000010, DASH};

  logic s1_q, s2_q, lvl, prev_q, pulse_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn_load;
      s2_q    <= s1_q;
      prev_q  <= lvl;
      pulse_q <= lvl & ~prev_q;
    end
  end

`ifdef ADDER_FND_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          deb_q, deb_d, deb_done;

  always_comb begin
    deb_done  = deb_cnt_q == DW'(DEBOUNCE_CYC - 1);
    deb_cnt_d = (s2_q == deb_q || deb_done) ? '0 : deb_cnt_q + 1'b1;
    deb_d     = (s2_q != deb_q && deb_done) ? s2_q : deb_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt_q <= '0;
      deb_q     <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      deb_q     <= deb_d;
    end
  end

  assign lvl = deb_q;
`else
  logic unused_deb;
  assign unused_deb = ^DEBOUNCE_CYC;
  assign lvl        = s2_q;
`endif

  logic [1:0]    a_q, a_d, b_q, b_d, idx_q, idx_d;
  logic [2:0]    r_q, r_d, digit;
  logic          valid_q, valid_d, wrap, dp_q;
  logic [SW-1:0] scan_q, scan_d;
  logic [6:0]    seg_q, seg_d, pick;
  logic [3:0]    an_q, an_d;

  // Display is fed from next-state values so a capture on a slot switch shows in the new slot.
  always_comb begin
    a_d     = pulse_q ? opa : a_q;
    b_d     = pulse_q ? opb : b_q;
    r_d     = pulse_q ? sum_in : r_q;
    valid_d = valid_q | pulse_q;
    wrap    = scan_q == SW'(SCAN_DIV - 1);
    scan_d  = wrap ? '0 : scan_q + 1'b1;
    idx_d   = wrap ? idx_q + 1'b1 : idx_q;
    digit   = idx_d == 2'd0 ? r_d : idx_d == 2'd2 ? {1'b0, b_d} : {1'b0, a_d};
    pick    = idx_d == 2'd1 ? BLANK : !valid_d ? DASH : SEG_LUT[digit];
    seg_d   = wrap ? pick : seg_q;
    an_d    = wrap ? ~(4'b0001 << idx_d) : an_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      seg_q   <= DASH;
      an_q    <= 4'b1110;
      dp_q    <= 1'b1;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      valid_q <= valid_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= 1'b1;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign dp    = dp_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_adder_result_fnd.sv
// tb_adder_result_fnd: directed tests of capture latency, debouncing, scan timing and digit encoding.
module tb_adder_result_fnd;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;
`ifdef ADDER_FND_DEBOUNCE_EN
  localparam int LAT = DEB + 3;
`else
  localparam int LAT = 3;
`endif
  localparam logic [6:0] DASH = 7'b0111111, BLANK = 7'b1111111;

  logic       clk = 1'b0, reset = 1'b0, btn_load = 1'b0;
  logic [1:0] opa = '0, opb = '0;
  logic [2:0] sum_in = '0;
  logic [6:0] seg;
  logic       dp, valid;
  logic [3:0] an;
  int n_chk = 0, n_fail = 0;

  adder_result_fnd #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CYC(DEB)) dut (
    .clk(clk), .reset(reset), .btn_load(btn_load), .opa(opa), .opb(opb),
    .sum_in(sum_in), .seg(seg), .dp(dp), .an(an), .valid(valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] t);
    for (int i = 0; i < 4 * SCAN_DIV + 2 && an !== t; i++) tick();
  endtask

  task automatic test_reset();
    logic [3:0] seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    logic [6:0] sx  [4] = '{BLANK, DASH, DASH, DASH};
    btn_load = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    n_chk++;
    if (an !== 4'b1110 || seg !== DASH || dp !== 1'b1 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: an=%b seg=%b dp=%b valid=%b, want 1110 0111111 1 0", an, seg, dp, valid);
    end
    reset = 1'b0;
    for (int s = 0; s < 4; s++) begin
      repeat (SCAN_DIV - 1) tick();
      n_chk++;
      if (an !== (s == 0 ? 4'b1110 : seq[s-1])) begin
        n_fail++;
        $display("FAIL reset_slot_hold%0d: an=%b changed early", s, an);
      end
      tick();
      n_chk++;
      if (an !== seq[s] || seg !== sx[s] || dp !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_scan%0d: an=%b seg=%b dp=%b, want an=%b seg=%b dp=1", s, an, seg, dp, seq[s], sx[s]);
      end
    end
  endtask

  task automatic check_capture_timing(input string name);
    repeat (LAT) tick();
    n_chk++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_early: valid=%b one cycle before capture, want 0", name, valid);
    end
    tick();
    n_chk++;
    if (valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_latency: valid=%b at capture edge, want 1", name, valid);
    end
  endtask

  task automatic check_digits(input string name, input logic [6:0] e0, input logic [6:0] e2, input logic [6:0] e3);
    repeat (4 * SCAN_DIV) tick();
    wait_an(4'b1110);
    n_chk++;
    if (an !== 4'b1110 || seg !== e0) begin n_fail++; $display("FAIL %s_idx0: an=%b seg=%b, want 1110 %b", name, an, seg, e0); end
    wait_an(4'b1101);
    n_chk++;
    if (an !== 4'b1101 || seg !== BLANK) begin n_fail++; $display("FAIL %s_idx1: an=%b seg=%b, want 1101 %b", name, an, seg, BLANK); end
    wait_an(4'b1011);
    n_chk++;
    if (an !== 4'b1011 || seg !== e2) begin n_fail++; $display("FAIL %s_idx2: an=%b seg=%b, want 1011 %b", name, an, seg, e2); end
    wait_an(4'b0111);
    n_chk++;
    if (an !== 4'b0111 || seg !== e3) begin n_fail++; $display("FAIL %s_idx3: an=%b seg=%b, want 0111 %b", name, an, seg, e3); end
  endtask

  task automatic test_basic_capture();
    do_reset();
    opa = 2'd3; opb = 2'd2; sum_in = 3'd5;
    btn_load = 1'b1;
    check_capture_timing("basic");
    repeat (20 - LAT - 1) tick();
    btn_load = 1'b0;
    check_digits("basic", 7'b0010010, 7'b0100100, 7'b0110000);
  endtask

  task automatic test_hold_release();
    do_reset();
    opa = 2'd1; opb = 2'd0; sum_in = 3'd1;
    btn_load = 1'b1;
    check_capture_timing("hold");
    opa = 2'd2; opb = 2'd2; sum_in = 3'd4;
    repeat (10) tick();
    btn_load = 1'b0;
    repeat (DEB + 10) tick();
    check_digits("hold", 7'b1111001, 7'b1000000, 7'b1111001);
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    repeat (2) tick();
    btn_load = 1'b1;
    repeat (LAT - 2) tick();
    reset = 1'b1;
    btn_load = 1'b0;
    repeat (3) tick();
    n_chk++;
    if (an !== 4'b1110 || seg !== DASH || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: an=%b seg=%b valid=%b, want 1110 0111111 0", an, seg, valid);
    end
    reset = 1'b0;
    repeat (SCAN_DIV - 1) tick();
    n_chk++;
    if (an !== 4'b1110) begin n_fail++; $display("FAIL midreset_restart: an=%b, want 1110", an); end
    tick();
    n_chk++;
    if (an !== 4'b1101) begin n_fail++; $display("FAIL midreset_step: an=%b, want 1101", an); end
    repeat (3 * DEB) tick();
    n_chk++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL midreset_nocapture: valid=%b, want 0", valid); end
  endtask

  task automatic test_held_through_reset();
    opa = 2'd0; opb = 2'd3; sum_in = 3'd3;
    btn_load = 1'b1;
    do_reset();
    check_capture_timing("heldreset");
    btn_load = 1'b0;
    check_digits("heldreset", 7'b0110000, 7'b0110000, 7'b1000000);
  endtask

  task automatic test_sum7_dash();
    do_reset();
    opa = 2'd3; opb = 2'd3; sum_in = 3'd7;
    btn_load = 1'b1;
    check_capture_timing("sum7");
    btn_load = 1'b0;
    check_digits("sum7", DASH, 7'b0110000, 7'b0110000);
  endtask

`ifdef ADDER_FND_DEBOUNCE_EN
  task automatic test_bounce();
    do_reset();
    opa = 2'd1; opb = 2'd2; sum_in = 3'd3;
    for (int p = 0; p < 5; p++) begin
      btn_load = 1'b1;
      repeat (3) tick();
      btn_load = 1'b0;
      repeat (3) tick();
    end
    n_chk++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL bounce_reject: valid=%b during bouncing, want 0", valid); end
    btn_load = 1'b1;
    check_capture_timing("bounce");
    btn_load = 1'b0;
    check_digits("bounce", 7'b0110000, 7'b0100100, 7'b1111001);
  endtask

  task automatic test_short_pulse();
    do_reset();
    btn_load = 1'b1;
    repeat (DEB - 1) tick();
    btn_load = 1'b0;
    repeat (3 * DEB) tick();
    n_chk++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL short_pulse: valid=%b, want 0", valid); end
  endtask
`else
  task automatic test_no_debounce();
    do_reset();
    opa = 2'd2; opb = 2'd1; sum_in = 3'd3;
    btn_load = 1'b1;
    tick();
    btn_load = 1'b0;
    repeat (2) tick();
    n_chk++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL nodeb_early: valid=%b at k+2, want 0", valid); end
    tick();
    n_chk++;
    if (valid !== 1'b1) begin n_fail++; $display("FAIL nodeb_latency: valid=%b at k+3, want 1", valid); end
    check_digits("nodeb", 7'b0110000, 7'b1111001, 7'b0100100);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_capture();
    test_hold_release();
    test_reset_mid_op();
    test_held_through_reset();
    test_sum7_dash();
`ifdef ADDER_FND_DEBOUNCE_EN
    test_bounce();
    test_short_pulse();
`else
    test_no_debounce();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
